// File: rtl/bonus_drop_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bonus_drop_ctrl : multi-slot spawner/mover for falling bonus items
// Revision: 1.0
// ---------------------------------------------------------------------------
module bonus_drop_ctrl #(
  parameter int NUM_SLOTS    = 3,
  parameter int TYPE_W       = 2,
  parameter int ITEM_WIDTH   = 24,
  parameter int ITEM_HEIGHT  = 24,
  parameter int SCREEN_W     = 640,
  parameter int FLOOR_Y      = 479,
  parameter int FALL_STEP    = 3,
  parameter int SPAWN_PERIOD = 24,
  parameter int LAND_FRAMES  = 60
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          startOfFrame,
  input  logic                          tick,
  input  logic                          freeze,
  input  logic [10:0]                   rand_x,
  input  logic [TYPE_W-1:0]             rand_type,
  input  logic [NUM_SLOTS-1:0]          collect,
  output logic [NUM_SLOTS*11-1:0]       topLeftX,
  output logic [NUM_SLOTS*11-1:0]       topLeftY,
  output logic [NUM_SLOTS*TYPE_W-1:0]   item_type,
  output logic [NUM_SLOTS-1:0]          active,
  output logic                          collect_valid,
  output logic [TYPE_W-1:0]             collect_type
);

  localparam int          TMR_W  = $clog2(SPAWN_PERIOD + 1);
  localparam int          LAND_W = $clog2(LAND_FRAMES + 1);
  localparam logic [10:0] OFF    = 11'h7FF;
  localparam logic [10:0] X_MAX  = 11'(SCREEN_W - ITEM_WIDTH);
  localparam logic [10:0] Y_LAND = 11'(FLOOR_Y - ITEM_HEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FALL   = 2'd1,
    ST_LANDED = 2'd2
  } slot_state_t;

  logic [NUM_SLOTS-1:0] idle_vec;
  logic [NUM_SLOTS-1:0] collected;
  logic [NUM_SLOTS-1:0] spawn_sel;
  logic                 spawn_go;
  logic                 found;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 collect_valid_q, collect_valid_d;
  logic [TYPE_W-1:0]    collect_type_q, collect_type_d;

  assign collected = collect & ~idle_vec;
  assign spawn_go  = (timer_q == TMR_W'(1)) && !freeze && (|idle_vec);

  // Lowest-index idle slot; a slot being collected this cycle is not idle yet.
  always_comb begin
    spawn_sel = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idle_vec[i] && !found) begin
        spawn_sel[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (!freeze) begin
      if (timer_q == TMR_W'(1)) begin
        if (spawn_go) timer_d = TMR_W'(SPAWN_PERIOD);
      end else if (tick) begin
        timer_d = timer_q - TMR_W'(1);
      end
    end
  end

  always_comb begin
    collect_valid_d = |collected;
    collect_type_d  = collect_type_q;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (collected[i]) collect_type_d = item_type[i*TYPE_W +: TYPE_W];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      timer_q         <= TMR_W'(SPAWN_PERIOD);
      collect_valid_q <= 1'b0;
      collect_type_q  <= '0;
    end else begin
      timer_q         <= timer_d;
      collect_valid_q <= collect_valid_d;
      collect_type_q  <= collect_type_d;
    end
  end

  assign collect_valid = collect_valid_q;
  assign collect_type  = collect_type_q;

  generate
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      slot_state_t       state_q, state_d;
      logic [10:0]       x_q, x_d, y_q, y_d;
      logic [TYPE_W-1:0] type_q, type_d;
      logic [LAND_W-1:0] land_q, land_d;
      logic [11:0]       y_step;

      assign y_step = {1'b0, y_q} + 12'(FALL_STEP);

      always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        type_d  = type_q;
        land_d  = land_q;
        if (collected[g]) begin
          state_d = ST_IDLE;
          x_d     = OFF;
          y_d     = OFF;
        end else if (spawn_go && spawn_sel[g]) begin
          state_d = ST_FALL;
          x_d     = (rand_x > X_MAX) ? X_MAX : rand_x;
          y_d     = 11'd0;
          type_d  = rand_type;
        end else if (startOfFrame && !freeze) begin
          case (state_q)
            ST_FALL: begin
              if (y_step >= {1'b0, Y_LAND}) begin
                y_d     = Y_LAND;
                state_d = ST_LANDED;
                land_d  = LAND_W'(LAND_FRAMES);
              end else begin
                y_d = y_step[10:0];
              end
            end
            ST_LANDED: begin
              land_d = land_q - LAND_W'(1);
              if (land_q <= LAND_W'(1)) begin
                state_d = ST_IDLE;
                x_d     = OFF;
                y_d     = OFF;
              end
            end
            default: ;
          endcase
        end
      end

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          state_q <= ST_IDLE;
          x_q     <= OFF;
          y_q     <= OFF;
          type_q  <= '0;
          land_q  <= '0;
        end else begin
          state_q <= state_d;
          x_q     <= x_d;
          y_q     <= y_d;
          type_q  <= type_d;
          land_q  <= land_d;
        end
      end

      assign idle_vec[g]                   = (state_q == ST_IDLE);
      assign active[g]                     = (state_q != ST_IDLE);
      assign topLeftX[g*11 +: 11]          = x_q;
      assign topLeftY[g*11 +: 11]          = y_q;
      assign item_type[g*TYPE_W +: TYPE_W] = type_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bonus_drop_ctrl.sv
`default_nettype none
// Randomized bench for bonus_drop_ctrl: behavioural slot model feeds a
// scoreboard queue that a negedge monitor drains against the DUT outputs.
module tb_bonus_drop_ctrl;
  localparam int NS     = 3;
  localparam int TW     = 2;
  localparam int X_LIM  = 640 - 24;
  localparam int Y_REST = 479 - 24;
  localparam int NCYC   = 7000;

  logic          clk = 1'b0;
  logic          resetN;
  logic          startOfFrame, tick, freeze;
  logic [10:0]   rand_x;
  logic [TW-1:0] rand_type;
  logic [NS-1:0] collect;
  logic [NS*11-1:0] topLeftX, topLeftY;
  logic [NS*TW-1:0] item_type;
  logic [NS-1:0] active;
  logic          collect_valid;
  logic [TW-1:0] collect_type;

  always #5 clk = ~clk;

  bonus_drop_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .tick(tick),
    .freeze(freeze), .rand_x(rand_x), .rand_type(rand_type), .collect(collect),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .item_type(item_type),
    .active(active), .collect_valid(collect_valid), .collect_type(collect_type)
  );

  typedef struct {
    logic [NS*11-1:0] x;
    logic [NS*11-1:0] y;
    logic [NS*TW-1:0] ty;
    logic [NS-1:0]    act;
    logic             cv;
    logic [TW-1:0]    ct;
    logic             rst;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: each slot is "on" (falling or resting) or empty.
  bit m_on[NS];
  bit m_landed[NS];
  int m_x[NS], m_y[NS], m_ty[NS], m_left[NS];
  int m_timer;
  bit m_cv;
  int m_ct;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_on[i] = 0; m_landed[i] = 0; m_x[i] = 0; m_y[i] = 0; m_ty[i] = 0; m_left[i] = 0;
    end
    m_timer = 24; m_cv = 0; m_ct = 0;
  endtask

  task automatic model_step(input bit sof, input bit tk, input bit frz,
                            input int rx, input int rt, input bit [NS-1:0] col);
    int sel;
    bit spawn;
    bit [NS-1:0] got;
    sel = -1;
    for (int i = 0; i < NS; i++) if (!m_on[i] && sel < 0) sel = i;
    spawn = (m_timer == 1) && !frz && (sel >= 0);
    got = '0;
    for (int i = 0; i < NS; i++) if (col[i] && m_on[i]) got[i] = 1'b1;
    m_cv = (got != 0);
    if (m_cv) for (int i = NS - 1; i >= 0; i--) if (got[i]) m_ct = m_ty[i];
    for (int i = 0; i < NS; i++) begin
      if (got[i]) m_on[i] = 0;
      else if (spawn && i == sel) begin
        m_on[i] = 1; m_landed[i] = 0; m_y[i] = 0; m_ty[i] = rt;
        m_x[i] = (rx > X_LIM) ? X_LIM : rx;
      end else if (sof && !frz && m_on[i]) begin
        if (!m_landed[i]) begin
          if (m_y[i] + 3 >= Y_REST) begin
            m_y[i] = Y_REST; m_landed[i] = 1; m_left[i] = 60;
          end else m_y[i] = m_y[i] + 3;
        end else begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) m_on[i] = 0;
        end
      end
    end
    if (!frz) begin
      if (m_timer == 1) begin
        if (spawn) m_timer = 24;
      end else if (tk) m_timer = m_timer - 1;
    end
  endtask

  function automatic exp_t snapshot(input bit rst);
    exp_t e;
    e.x = '0; e.y = '0; e.ty = '0; e.act = '0;
    for (int i = 0; i < NS; i++) begin
      e.x[i*11 +: 11]  = m_on[i] ? 11'(m_x[i]) : 11'h7FF;
      e.y[i*11 +: 11]  = m_on[i] ? 11'(m_y[i]) : 11'h7FF;
      e.ty[i*TW +: TW] = TW'(m_ty[i]);
      e.act[i]         = m_on[i];
    end
    e.cv  = m_cv;
    e.ct  = TW'(m_ct);
    e.rst = rst;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      logic [NS*TW-1:0] m;
      e = sbq.pop_front();
      m = '0;
      for (int i = 0; i < NS; i++) if (e.act[i]) m[i*TW +: TW] = '1;
      chk("active", 64'(active), 64'(e.act));
      chk("topLeftX", 64'(topLeftX), 64'(e.x));
      chk("topLeftY", 64'(topLeftY), 64'(e.y));
      chk("item_type", 64'(item_type & m), 64'(e.ty & m));
      chk("collect_valid", 64'(collect_valid), 64'(e.cv));
      if (e.cv || e.rst) chk("collect_type", 64'(collect_type), 64'(e.ct));
    end
  end

  function automatic logic [10:0] pick_x();
    case ($urandom_range(0, 7))
      0: return 11'd630;
      1: return 11'd100;
      2: return 11'(X_LIM);
      3: return 11'(X_LIM + 1);
      4: return 11'h7FF;
      default: return 11'($urandom_range(0, 2047));
    endcase
  endfunction

  initial begin
    int frz_left;
    resetN = 1'b0; startOfFrame = 0; tick = 0; freeze = 0;
    rand_x = '0; rand_type = '0; collect = '0;
    frz_left = 0;
    repeat (3) begin
      @(negedge clk); #1;
      model_reset();
      sbq.push_back(snapshot(1'b1));
    end
    @(negedge clk); #1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      startOfFrame = (cyc % 3 == 0);
      tick         = (cyc < 2500) ? (cyc % 4 == 0) : ($urandom_range(0, 2) == 0);
      rand_x       = pick_x();
      rand_type    = TW'($urandom);
      collect      = '0;
      freeze       = 1'b0;
      if (cyc >= 1000 && cyc < 1030) freeze = 1'b1;
      if (cyc == 1015) collect = 3'b001;
      if (cyc == 1400) collect = 3'b010;
      if (cyc == 1600) collect = 3'b110;
      if (cyc >= 2500) begin
        if (frz_left > 0) begin
          freeze = 1'b1; frz_left--;
        end else if ($urandom_range(0, 149) == 0) frz_left = 30;
        if ($urandom_range(0, 59) == 0) collect = NS'($urandom_range(1, 7));
      end
      if (cyc == 5000 || cyc == 5001) begin
        resetN = 1'b0;
        model_reset();
        sbq.push_back(snapshot(1'b1));
      end else begin
        resetN = 1'b1;
        model_step(startOfFrame, tick, freeze, int'(rand_x), int'(rand_type), collect);
        sbq.push_back(snapshot(1'b0));
      end
      @(negedge clk); #1;
    end
    collect = '0; freeze = 0; tick = 0; startOfFrame = 0;
    @(negedge clk); #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/bonus_drop_ctrl.md
Name: bonus_drop_ctrl

Overview:
- Multi-slot spawner and mover for falling bonus items such as lives and power-ups.
- Periodically drops items from the top of the screen at a random X. Each item falls once per frame, rests on the floor for a fixed number of frames, then disappears.
- The player can collect any active item; each collect is reported once to the score/life logic.
- Feeds the per-slot item drawers and the collision matrix.

Parameters:
- NUM_SLOTS, 3, number of concurrent items.
- TYPE_W, 2, width of the item-type code.
- ITEM_WIDTH, 24, item width in pixels.
- ITEM_HEIGHT, 24, item height in pixels.
- SCREEN_W, 640, visible width in pixels.
- FLOOR_Y, 479, bottom visible row.
- FALL_STEP, 3, pixels moved per frame while falling.
- SPAWN_PERIOD, 24, number of tick pulses between spawns.
- LAND_FRAMES, 60, frames an item rests on the floor before vanishing.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- tick  in  1  one-cycle spawn-timer enable (slow pulse).
- freeze  in  1  pauses motion, landed countdown and spawn timer.
- rand_x  in  11  random X candidate.
- rand_type  in  TYPE_W  random type for the next spawn.
- collect  in  NUM_SLOTS  per-slot crash/collect from the collision logic.
- topLeftX  out  NUM_SLOTS*11  slot i occupies bits [11i+10:11i].
- topLeftY  out  NUM_SLOTS*11  same packing as topLeftX.
- item_type  out  NUM_SLOTS*TYPE_W  type of each slot.
- active  out  NUM_SLOTS  slot holds a visible item.
- collect_valid  out  1  one-cycle pulse when at least one item is collected.
- collect_type  out  TYPE_W  type of the lowest-index collected item.

Behaviour:
- Reset: resetN, asynchronous, active-low; clock clk. All registers are clocked on posedge clk.
  - All slots go to IDLE.
  - topLeftX and topLeftY go to 11'h7FF (off-screen).
  - item_type=0, active=0, collect_valid=0, collect_type=0.
  - Spawn timer = SPAWN_PERIOD.
- Per-slot FSM states: IDLE, FALL, LANDED. active=1 in FALL and LANDED only.
- In IDLE, X and Y are held at 11'h7FF.
- Spawn timer:
  - Counts down by 1 on each cycle with tick=1, freeze=0 and timer>1.
  - When timer==1 and at least one IDLE slot exists, and freeze=0, spawn into the lowest-index IDLE slot and reload the timer to SPAWN_PERIOD. A tick in that same cycle is ignored.
  - When timer==1 and no slot is IDLE, the timer holds at 1. The spawn fires in the first cycle a slot is IDLE.
- Spawn (slot IDLE -> FALL, takes effect next cycle):
  - X = min(rand_x, SCREEN_W-ITEM_WIDTH).
  - Y = 0.
  - item_type = rand_type, sampled on the spawn cycle.
- FALL, on startOfFrame with freeze=0:
  - If Y+FALL_STEP >= FLOOR_Y-ITEM_HEIGHT: Y = FLOOR_Y-ITEM_HEIGHT (455 at defaults), state -> LANDED, land counter = LAND_FRAMES.
  - Otherwise Y = Y+FALL_STEP.
  - Compute Y+FALL_STEP in 12 bits so there is no wrap.
- LANDED, on startOfFrame with freeze=0: land counter decrements. On the frame it reaches 0, the slot goes to IDLE and X,Y go to 7FF.
- Collect:
  - collect[i]=1 while slot i is in FALL or LANDED forces slot i to IDLE next cycle. Collect has priority over motion, landing and timeout in the same cycle.
  - collect[i] on an IDLE slot is ignored.
  - collect_valid/collect_type are registered: they assert the cycle after the collect, for exactly one cycle.
  - If several slots are collected at once, all are freed, collect_valid pulses once, and collect_type reports the lowest-index collected slot.
  - collect must be an edge from the collision logic. A slot that is re-spawned while collect is still high is collected again.
- Same-cycle spawn and collect: the slot being collected is not IDLE during that cycle, so spawn picks another IDLE slot or waits. The freed slot becomes eligible on the following cycle.
- freeze=1: positions, land counters and the spawn timer hold. collect still works.
- Reset mid-operation returns everything to reset values immediately; no pulse is emitted.

Test Plan:
- Reset release, tick every 4 cycles, SPAWN_PERIOD=24 -> first spawn into slot 0 after 23 ticks; slot 0 then shows Y=0, active=001, item_type=rand_type.
- rand_x=630 at spawn -> slot X=616; rand_x=100 -> X=100.
- Falling item, 152 startOfFrame pulses -> Y=455 and state LANDED; after 60 more frames -> active bit clears and X=Y=7FF, with no collect_valid.
- All 3 slots active and timer reaches 1 -> timer holds at 1. collect[1] pulse -> collect_valid one cycle later with slot 1's type; the next spawn goes into slot 1 on the cycle after slot 1 is freed.
- collect=3'b110 in one cycle -> both slots freed, single collect_valid pulse, collect_type = slot 1's type.
- freeze=1 for 10 frames mid-fall -> Y and timer unchanged; collect[0] during freeze -> slot 0 freed and pulse emitted.
